// File: rtl/seg_scan_ctrl.sv
// Scan sequencer for an 8-digit multiplexed seven-segment display.
// Optional dimming via `define SEG_SCAN_BRIGHT_EN (adds the brightness port).
module seg_scan_ctrl #(
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] digit_mask,
`ifdef SEG_SCAN_BRIGHT_EN
    input  logic [3:0] brightness,
`endif
    output logic [2:0] seven_seg_scan,
    output logic       blank,
    output logic       frame_done
);

    localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit NO_GAP = (BLANK_CYCLES == 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

`ifdef SEG_SCAN_BRIGHT_EN
    localparam int unsigned DW_W   = $clog2(DWELL_CYCLES + 1);
    localparam int unsigned PROD_W = DW_W + 4;
    localparam int unsigned CMP_W  = ((CNT_W > DW_W) ? CNT_W : DW_W) + 1;

    logic [DW_W-1:0] thr, thr_nxt;
    logic [PROD_W-1:0] prod;
`endif

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       scan_nxt;
    logic             blank_nxt;
    logic             fd_nxt;
    logic             step_hit;
    logic [2:0]       step_idx;
    logic [2:0]       first_idx;

    // First enabled index after cur (cur itself last); {found, index}.
    function automatic logic [3:0] next_digit(input logic [2:0] cur, input logic [7:0] mask);
        logic       hit;
        logic [2:0] idx;
        logic [2:0] cand;
        hit = 1'b0;
        idx = cur;
        for (int i = 1; i <= 8; i++) begin
            cand = cur + 3'(i);
            if (!hit && mask[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
        return {hit, idx};
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            seven_seg_scan <= 3'd0;
            blank          <= 1'b1;
            frame_done     <= 1'b0;
`ifdef SEG_SCAN_BRIGHT_EN
            thr            <= '0;
`endif
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            seven_seg_scan <= scan_nxt;
            blank          <= blank_nxt;
            frame_done     <= fd_nxt;
`ifdef SEG_SCAN_BRIGHT_EN
            thr            <= thr_nxt;
`endif
        end
    end

    // Next state, counter and registered-output values.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        scan_nxt  = seven_seg_scan;
        blank_nxt = blank;
        fd_nxt    = 1'b0;
`ifdef SEG_SCAN_BRIGHT_EN
        thr_nxt   = thr;
        prod      = (PROD_W'(brightness) + PROD_W'(1)) * PROD_W'(DWELL_CYCLES);
`endif
        {step_hit, step_idx} = next_digit(seven_seg_scan, digit_mask);
        first_idx = lowest_set(digit_mask);

        case (state)
            S_IDLE: begin
                blank_nxt = 1'b1;
                cnt_nxt   = '0;
                if (en && (digit_mask != 8'd0)) begin
                    scan_nxt  = first_idx;
                    state_nxt = NO_GAP ? S_SHOW : S_BLANK;
                end
            end
            S_BLANK: begin
                blank_nxt = 1'b1;
                if (cnt == BLANK_LAST) begin
                    state_nxt = S_SHOW;
                    cnt_nxt   = '0;
                end
            end
            S_SHOW: begin
                if (cnt == DWELL_LAST) begin
                    cnt_nxt = '0;
                    if (!step_hit) begin
                        state_nxt = S_IDLE;
                        blank_nxt = 1'b1;
                    end else begin
                        scan_nxt  = step_idx;
                        fd_nxt    = (step_idx <= seven_seg_scan);
                        state_nxt = NO_GAP ? S_SHOW : S_BLANK;
                        blank_nxt = 1'b1;
                    end
                end else begin
`ifdef SEG_SCAN_BRIGHT_EN
                    blank_nxt = !((CMP_W'(cnt) + CMP_W'(1)) < CMP_W'(thr));
`else
                    blank_nxt = 1'b0;
`endif
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                blank_nxt = 1'b1;
            end
        endcase

        // Any entry into SHOW lights the digit (threshold resampled when dimming).
        if (state_nxt == S_SHOW && cnt_nxt == '0 && !(state == S_SHOW && cnt != DWELL_LAST)) begin
`ifdef SEG_SCAN_BRIGHT_EN
            thr_nxt   = DW_W'(prod >> 4);
            blank_nxt = (thr_nxt == '0);
`else
            blank_nxt = 1'b0;
`endif
        end

        if (!en) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            scan_nxt  = seven_seg_scan;
            blank_nxt = 1'b1;
            fd_nxt    = 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: checkpoint table plus directed corner sequences.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] digit_mask;
    logic [3:0] brightness;

    logic [2:0] scan_g, scan_n;
    logic       blank_g, blank_n, fd_g, fd_n;
`ifdef SEG_SCAN_BRIGHT_EN
    logic [2:0] scan_b;
    logic       blank_b, fd_b;
`endif

    int checks = 0;
    int errors = 0;
    int k;

    typedef struct {
        logic [7:0] mask;
        int         k;
        logic [2:0] scan;
        logic       blank;
        logic       fd;
    } vec_t;

    vec_t vecs[27];

    seg_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) u_gap (
        .clk(clk), .rst(rst), .en(en), .digit_mask(digit_mask),
`ifdef SEG_SCAN_BRIGHT_EN
        .brightness(brightness),
`endif
        .seven_seg_scan(scan_g), .blank(blank_g), .frame_done(fd_g)
    );

    seg_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(0)) u_nogap (
        .clk(clk), .rst(rst), .en(en), .digit_mask(digit_mask),
`ifdef SEG_SCAN_BRIGHT_EN
        .brightness(brightness),
`endif
        .seven_seg_scan(scan_n), .blank(blank_n), .frame_done(fd_n)
    );

`ifdef SEG_SCAN_BRIGHT_EN
    seg_scan_ctrl #(.DWELL_CYCLES(16), .BLANK_CYCLES(2)) u_bright (
        .clk(clk), .rst(rst), .en(en), .digit_mask(digit_mask),
        .brightness(brightness),
        .seven_seg_scan(scan_b), .blank(blank_b), .frame_done(fd_b)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %0d expected %0d", name, k, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    // Reset for 3 cycles, verify reset values, then enable with mask m.
    task automatic start(input logic [7:0] m);
        rst = 1'b1;
        en = 1'b0;
        digit_mask = m;
        repeat (3) @(negedge clk);
        chk("rst_scan", 32'(scan_g), 32'd0);
        chk("rst_blank", 32'(blank_g), 32'd1);
        chk("rst_fd", 32'(fd_g), 32'd0);
        rst = 1'b0;
        en = 1'b1;
        k = -1;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        digit_mask = 8'h00;
        brightness = 4'd15;
        k = -1;

        vecs[0]  = '{8'hFF, 0,  3'd0, 1'b1, 1'b0};
        vecs[1]  = '{8'hFF, 2,  3'd0, 1'b0, 1'b0};
        vecs[2]  = '{8'hFF, 5,  3'd0, 1'b0, 1'b0};
        vecs[3]  = '{8'hFF, 6,  3'd1, 1'b1, 1'b0};
        vecs[4]  = '{8'hFF, 8,  3'd1, 1'b0, 1'b0};
        vecs[5]  = '{8'hFF, 47, 3'd7, 1'b0, 1'b0};
        vecs[6]  = '{8'hFF, 48, 3'd0, 1'b1, 1'b1};
        vecs[7]  = '{8'hFF, 49, 3'd0, 1'b1, 1'b0};
        vecs[8]  = '{8'hFF, 50, 3'd0, 1'b0, 1'b0};
        vecs[9]  = '{8'hFF, 96, 3'd0, 1'b1, 1'b1};
        vecs[10] = '{8'h85, 0,  3'd0, 1'b1, 1'b0};
        vecs[11] = '{8'h85, 2,  3'd0, 1'b0, 1'b0};
        vecs[12] = '{8'h85, 6,  3'd2, 1'b1, 1'b0};
        vecs[13] = '{8'h85, 8,  3'd2, 1'b0, 1'b0};
        vecs[14] = '{8'h85, 12, 3'd7, 1'b1, 1'b0};
        vecs[15] = '{8'h85, 17, 3'd7, 1'b0, 1'b0};
        vecs[16] = '{8'h85, 18, 3'd0, 1'b1, 1'b1};
        vecs[17] = '{8'h85, 19, 3'd0, 1'b1, 1'b0};
        vecs[18] = '{8'h85, 24, 3'd2, 1'b1, 1'b0};
        vecs[19] = '{8'h85, 36, 3'd0, 1'b1, 1'b1};
        vecs[20] = '{8'h10, 0,  3'd4, 1'b1, 1'b0};
        vecs[21] = '{8'h10, 2,  3'd4, 1'b0, 1'b0};
        vecs[22] = '{8'h10, 5,  3'd4, 1'b0, 1'b0};
        vecs[23] = '{8'h10, 6,  3'd4, 1'b1, 1'b1};
        vecs[24] = '{8'h10, 7,  3'd4, 1'b1, 1'b0};
        vecs[25] = '{8'h10, 8,  3'd4, 1'b0, 1'b0};
        vecs[26] = '{8'h10, 12, 3'd4, 1'b1, 1'b1};

        // Checkpoint table: restart whenever the mask changes.
        for (int i = 0; i < 27; i++) begin
            if (i == 0 || vecs[i].mask != digit_mask || vecs[i].k < k) start(vecs[i].mask);
            run_to(vecs[i].k);
            chk("tbl_scan", 32'(scan_g), 32'(vecs[i].scan));
            chk("tbl_blank", 32'(blank_g), 32'(vecs[i].blank));
            chk("tbl_fd", 32'(fd_g), 32'(vecs[i].fd));
        end

        // Full scan, every cycle, with and without the blanking gap.
        start(8'hFF);
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("full_scan", 32'(scan_g), 32'((k / 6) % 8));
            chk("full_blank", 32'(blank_g), 32'((k % 6) < 2));
            chk("full_fd", 32'(fd_g), 32'(k > 0 && (k % 48) == 0));
            chk("nogap_scan", 32'(scan_n), 32'((k / 4) % 8));
            chk("nogap_blank", 32'(blank_n), 32'd0);
            chk("nogap_fd", 32'(fd_n), 32'(k > 0 && (k % 32) == 0));
        end

        // Mask to zero mid-dwell of digit 2.
        start(8'hFF);
        run_to(15);
        digit_mask = 8'h00;
        tick();
        chk("mz_dwell_scan", 32'(scan_g), 32'd2);
        chk("mz_dwell_blank", 32'(blank_g), 32'd0);
        tick();
        chk("mz_last_blank", 32'(blank_g), 32'd0);
        tick();
        chk("mz_idle_scan", 32'(scan_g), 32'd2);
        chk("mz_idle_blank", 32'(blank_g), 32'd1);
        chk("mz_idle_fd", 32'(fd_g), 32'd0);
        repeat (2) tick();
        chk("mz_hold_scan", 32'(scan_g), 32'd2);
        chk("mz_hold_blank", 32'(blank_g), 32'd1);
        digit_mask = 8'hFF;
        tick();
        chk("mz_restart_scan", 32'(scan_g), 32'd0);
        chk("mz_restart_blank", 32'(blank_g), 32'd1);
        repeat (2) tick();
        chk("mz_restart_lit", 32'(blank_g), 32'd0);

        // en dropped mid-dwell.
        start(8'hFF);
        run_to(15);
        en = 1'b0;
        tick();
        chk("en_drop_scan", 32'(scan_g), 32'd2);
        chk("en_drop_blank", 32'(blank_g), 32'd1);
        chk("en_drop_fd", 32'(fd_g), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("en_idle_fd", 32'(fd_g), 32'd0);
            chk("en_idle_blank", 32'(blank_g), 32'd1);
        end
        en = 1'b1;
        tick();
        chk("en_resume_scan", 32'(scan_g), 32'd0);

        // en dropped on the wrapping step: no frame_done.
        start(8'hFF);
        run_to(47);
        en = 1'b0;
        tick();
        chk("en_wrap_scan", 32'(scan_g), 32'd7);
        chk("en_wrap_blank", 32'(blank_g), 32'd1);
        chk("en_wrap_fd", 32'(fd_g), 32'd0);

        // Reset mid-operation.
        start(8'hFF);
        run_to(20);
        rst = 1'b1;
        tick();
        chk("midrst_scan", 32'(scan_g), 32'd0);
        chk("midrst_blank", 32'(blank_g), 32'd1);
        chk("midrst_fd", 32'(fd_g), 32'd0);
        rst = 1'b0;

`ifdef SEG_SCAN_BRIGHT_EN
        // Dimming: brightness 3 -> 4 lit of 16, brightness 15 -> all 16 lit.
        brightness = 4'd3;
        start(8'hFF);
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("dim3_scan", 32'(scan_b), 32'((k / 18) % 8));
            chk("dim3_blank", 32'(blank_b), 32'((k % 18) < 2 || (k % 18) >= 6));
        end
        brightness = 4'd15;
        start(8'hFF);
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("dim15_scan", 32'(scan_b), 32'((k / 18) % 8));
            chk("dim15_blank", 32'(blank_b), 32'((k % 18) < 2));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
